// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch controller.
package inst_fetch_ctrl_pkg;

    // Bus widths and the zero word.
    localparam int unsigned RegBusW      = 32;
    localparam int unsigned InstBusW     = 32;
    localparam int unsigned InstAddrBusW = 32;
    localparam logic [InstBusW-1:0] ZeroWord = 32'h0000_0000;

    // Width of the saturating REQ-cycle counter.
    localparam int unsigned CntW = 10;

    // Fetch FSM encoding: IDLE = 0, REQ = 1, FILL = 2.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StFill = 2'd2
    } fetch_state_e;

    // A fetch address must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Request/acknowledge instruction bus between the fetch controller and memory.
interface inst_fetch_ctrl_if;
    import inst_fetch_ctrl_pkg::*;

    logic                    bus_req;
    logic [InstAddrBusW-1:0] bus_addr;
    logic                    bus_ack;
    logic [InstBusW-1:0]     bus_rdata;

    modport master (
        output bus_req,
        output bus_addr,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_addr,
        output bus_ack,
        output bus_rdata
    );

endinterface

// File: rtl/fetch_line_buf.sv
// One-entry fetch buffer: valid/address/data registers and the hit compare.
module fetch_line_buf
    import inst_fetch_ctrl_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ce_i,
    input  logic [InstAddrBusW-1:0] addr_i,
    output logic                    hit_o,
    output logic [InstBusW-1:0]     data_o,
    input  logic                    wr_en_i,
    input  logic [InstAddrBusW-1:0] wr_addr_i,
    input  logic [InstBusW-1:0]     wr_data_i
);

    logic                    valid_q, valid_d;
    logic [InstAddrBusW-1:0] addr_q, addr_d;
    logic [InstBusW-1:0]     data_q, data_d;

    // Next-state: a write loads the entry and marks it valid.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (wr_en_i) begin
            valid_d = 1'b1;
            addr_d  = wr_addr_i;
            data_d  = wr_data_i;
        end
    end

    // Entry registers; reset invalidates the buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= ZeroWord;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign hit_o  = ce_i && valid_q && (addr_q == addr_i);
    assign data_o = data_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: turns the core's single-cycle ROM port into
// req/ack bus reads, serving repeats of the last word from a one-entry buffer.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned          TIMEOUT_CYC = 255,
    parameter logic [InstBusW-1:0]  NOP_WORD    = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rom_ce_i,
    input  logic [InstAddrBusW-1:0] rom_addr_i,
    output logic [InstBusW-1:0]     rom_data_o,
    output logic                    stall_req_o,
    output logic                    fetch_err_o,
    inst_fetch_ctrl_if.master       bus
);

    // Timeout fires in the REQ cycle whose counter value is TIMEOUT_CYC-1,
    // i.e. after exactly TIMEOUT_CYC cycles of request without ack.
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);
    localparam logic [CntW-1:0] CntMax      = '1;

    fetch_state_e            state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    req_q, req_d;
    logic [InstAddrBusW-1:0] addr_q, addr_d;
    logic                    err_q, err_d;

    logic                    hit;
    logic [InstBusW-1:0]     buf_data;
    logic                    wr_en;
    logic [InstAddrBusW-1:0] wr_addr;
    logic [InstBusW-1:0]     wr_data;
    logic                    miss;

    fetch_line_buf u_line_buf (
        .clk_i     (clk),
        .rst_ni    (rst),
        .ce_i      (rom_ce_i),
        .addr_i    (rom_addr_i),
        .hit_o     (hit),
        .data_o    (buf_data),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data)
    );

    // Core-facing outputs are combinational so hits cost zero cycles.
    always_comb begin
        miss        = rom_ce_i && !hit;
        rom_data_o  = hit ? buf_data : ZeroWord;
        stall_req_o = miss;
    end

    // Fetch FSM next-state, counter, bus request and buffer write control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        addr_d  = addr_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_addr = addr_q;
        wr_data = NOP_WORD;

        unique case (state_q)
            StIdle: begin
                if (miss) begin
                    if (is_misaligned(rom_addr_i[1:0])) begin
                        // Misaligned fetch never reaches the bus; deliver a NOP.
                        wr_en   = 1'b1;
                        wr_addr = rom_addr_i;
                        wr_data = NOP_WORD;
                        err_d   = 1'b1;
                    end else begin
                        addr_d  = rom_addr_i;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                // Ack has priority over a simultaneous timeout.
                if (bus.bus_ack) begin
                    wr_en   = 1'b1;
                    wr_addr = addr_q;
                    wr_data = bus.bus_rdata;
                    req_d   = 1'b0;
                    state_d = StFill;
                end else if (cnt_q >= TimeoutLast) begin
                    wr_en   = 1'b1;
                    wr_addr = addr_q;
                    wr_data = NOP_WORD;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = StFill;
                end
            end
            StFill: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and bus-side registers; async reset drops the request immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign bus.bus_req  = req_q;
    assign bus.bus_addr = addr_q;
    assign fetch_err_o  = err_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: behavioural model plus directed pins
// and a randomized phase.
module tb_inst_fetch_ctrl;
    import inst_fetch_ctrl_pkg::*;

    localparam int unsigned TO  = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] rom_data;
    logic        stall;
    logic        err;

    inst_fetch_ctrl_if bus_if ();

    inst_fetch_ctrl #(
        .TIMEOUT_CYC (TO),
        .NOP_WORD    (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce_i    (ce),
        .rom_addr_i  (addr),
        .rom_data_o  (rom_data),
        .stall_req_o (stall),
        .fetch_err_o (err),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- bus responder ----------------
    int          ack_lat  = -1;
    bit          rand_ack = 1'b0;
    bit          junk     = 1'b0;
    bit          fixed_rd = 1'b0;
    logic [31:0] fixed_val = 32'h0;
    int          age = 0;
    int          cur_lat = -1;

    always @(posedge clk) begin
        #1;
        if (bus_if.bus_req) begin
            if (age == 0) cur_lat = rand_ack ? int'($urandom_range(0, 9)) : ack_lat;
            bus_if.bus_ack = (age == cur_lat);
            age++;
        end else begin
            age = 0;
            bus_if.bus_ack = junk ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
        bus_if.bus_rdata = fixed_rd ? fixed_val : $urandom;
    end

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for a miss, 1 bus read outstanding, 2 turnaround
    bit          m_bv;
    logic [31:0] m_ba, m_bd, m_baddr;
    bit          m_req, m_err;
    int          m_ph, m_wait;

    task automatic m_reset();
        m_bv = 0; m_ba = 0; m_bd = 0; m_baddr = 0;
        m_req = 0; m_err = 0; m_ph = 0; m_wait = 0;
    endtask

    function automatic bit m_hit();
        return ce && m_bv && (m_ba == addr);
    endfunction

    task automatic m_step();
        if (m_ph == 0) begin
            if (ce && !m_hit()) begin
                if (addr % 4 != 0) begin
                    m_bv = 1; m_ba = addr; m_bd = NOP; m_err = 1;
                end else begin
                    m_ph = 1; m_req = 1; m_baddr = addr; m_wait = 0;
                end
            end
        end else if (m_ph == 1) begin
            m_wait++;
            if (bus_if.bus_ack) begin
                m_bv = 1; m_ba = m_baddr; m_bd = bus_if.bus_rdata; m_req = 0; m_ph = 2;
            end else if (m_wait >= TO) begin
                m_bv = 1; m_ba = m_baddr; m_bd = NOP; m_err = 1; m_req = 0; m_ph = 2;
            end
        end else begin
            m_ph = 0;
        end
    endtask

    // Compare process: check every mid-cycle, advance model on each edge.
    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (!rst) m_reset();
            check("cyc_rom_data", rom_data, m_hit() ? m_bd : 32'h0);
            check("cyc_stall", {31'b0, stall}, {31'b0, ce && !m_hit()});
            check("cyc_fetch_err", {31'b0, err}, {31'b0, m_err});
            check("cyc_bus_req", {31'b0, bus_if.bus_req}, {31'b0, m_req});
            check("cyc_bus_addr", bus_if.bus_addr, m_baddr);
            @(posedge clk);
            if (rst) m_step();
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] tbl [6];

    initial begin
        int n_a, n_b, n_c;
        bit prev;
        logic [31:0] seen;
        logic [31:0] seq [3];
        tbl = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h6, 32'h1};
        seq = '{32'h0, 32'h4, 32'h8};
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
        #1 rst = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("reset_rom_data", rom_data, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);
        check("reset_err", {31'b0, err}, 32'h0);
        check("reset_bus_req", {31'b0, bus_if.bus_req}, 32'h0);
        check("reset_bus_addr", bus_if.bus_addr, 32'h0);
        step();
        rst = 1'b1;
        step();

        // First miss, ack three cycles after the request rises.
        fixed_rd = 1; fixed_val = 32'h3401_0020; ack_lat = 3;
        ce = 1; addr = 32'h0;
        n_a = 0; n_b = 0; prev = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (stall && bus_if.bus_req) n_a++;
            if (bus_if.bus_req && !prev) n_b++;
            prev = bus_if.bus_req;
        end
        check("miss_stall_cycles", n_a, 4);
        check("miss_req_trains", n_b, 1);
        check("miss_data", rom_data, 32'h3401_0020);
        n_a = 0; n_b = 0; n_c = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus_if.bus_req) n_a++;
            if (stall) n_b++;
            if (rom_data != 32'h3401_0020) n_c++;
        end
        check("hold_no_req", n_a, 0);
        check("hold_no_stall", n_b, 0);
        check("hold_data_unstable", n_c, 0);

        // Zero-wait sequential misses after a fresh reset.
        step(); rst = 0;
        step(); rst = 1;
        fixed_rd = 0; ack_lat = 0;
        for (int k = 0; k < 3; k++) begin
            addr = seq[k];
            n_a = 0; seen = 32'hFFFF_FFFF;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (stall && bus_if.bus_req) n_a++;
                if (bus_if.bus_req) seen = bus_if.bus_addr;
            end
            step();
            check("zw_stall_cycles", n_a, 1);
            check("zw_bus_addr", seen, seq[k]);
        end

        // Ack in the same cycle as the timeout: ack wins, no error.
        fixed_rd = 1; fixed_val = 32'hCAFE_0001; ack_lat = TO - 1;
        addr = 32'h40;
        repeat (12) @(negedge clk);
        check("collide_err", {31'b0, err}, 32'h0);
        check("collide_data", rom_data, 32'hCAFE_0001);
        step();

        // Misaligned fetch.
        addr = 32'h6;
        n_a = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_if.bus_req) n_a++;
        end
        check("misal_no_req", n_a, 0);
        check("misal_data", rom_data, NOP);
        check("misal_err", {31'b0, err}, 32'h1);
        check("misal_stall", {31'b0, stall}, 32'h0);
        step();
        ack_lat = 0; addr = 32'h8;
        repeat (4) @(negedge clk);
        check("err_sticky", {31'b0, err}, 32'h1);
        step();

        // Timeout with no ack.
        ack_lat = -1; addr = 32'h200;
        n_a = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus_if.bus_req) n_a++;
        end
        check("timeout_req_cycles", n_a, TO);
        check("timeout_data", rom_data, NOP);
        check("timeout_err", {31'b0, err}, 32'h1);
        step();

        // Reset in the second REQ cycle.
        addr = 32'h300;
        step();
        step();
        rst = 0;
        #1;
        check("rst_req_drop", {31'b0, bus_if.bus_req}, 32'h0);
        step();
        rst = 1; ack_lat = 2;
        @(negedge clk);
        check("rst_refetch_miss", {31'b0, stall}, 32'h1);
        n_a = 0; prev = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_if.bus_req && !prev) n_a++;
            prev = bus_if.bus_req;
        end
        check("rst_refetch_req", n_a, 1);
        check("rst_refetch_data", rom_data, 32'hCAFE_0001);
        step();

        // Randomized phase.
        fixed_rd = 0; rand_ack = 1; junk = 1;
        for (int i = 0; i < 2000; i++) begin
            ce = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) addr = tbl[$urandom_range(0, 5)];
            rst = ($urandom_range(0, 249) != 0);
            step();
        end
        rst = 1;
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
